// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_pkg: shared types, region encoding, data width and index-width helper for the memory bus arbiter
package mem_bus_pkg;
  localparam int DATA_W = 8;
  localparam logic [1:0] REGION_IO = 2'b11;
  typedef enum logic {REG_RAM = 1'b0, REG_IO = 1'b1} region_t;
  typedef enum logic {ARB_FREE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: master request/grant/read-return plus ram and io slave ports; slave = arbiter view, master = masters+memories view
interface mem_bus_arbiter_if import mem_bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH = 3
);
  logic [NUM_MASTERS-1:0] m_req;
  logic [NUM_MASTERS-1:0] m_lock;
  logic [NUM_MASTERS-1:0] m_wr;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0] m_gnt;
  logic [NUM_MASTERS-1:0] m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic ram_en;
  logic ram_r_nw;
  logic [RAM_ADDR_WIDTH-1:0] ram_a;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic io_en;
  logic io_wr;
  logic [IO_SEL_WIDTH-1:0] io_sel;
  logic [DATA_W-1:0] io_din;
  logic [DATA_W-1:0] io_dout;
  modport slave (
    input m_req, m_lock, m_wr, m_addr, m_wdata, ram_dout, io_dout,
    output m_gnt, m_rvalid, m_rdata, ram_en, ram_r_nw, ram_a, ram_din, io_en, io_wr, io_sel, io_din
  );
  modport master (
    output m_req, m_lock, m_wr, m_addr, m_wdata, ram_dout, io_dout,
    input m_gnt, m_rvalid, m_rdata, ram_en, ram_r_nw, ram_a, ram_din, io_en, io_wr, io_sel, io_din
  );
endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant with lock ownership; in req/lock/hold, out gnt, gnt_valid, gnt_idx
module rr_arbiter import mem_bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  localparam int IW = idx_w(NUM_MASTERS)
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] lock,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic gnt_valid,
  output logic [IW-1:0] gnt_idx
);
  arb_state_t state, state_n;
  logic [IW-1:0] owner, owner_n, ptr, ptr_n, start;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return int'(i) == NUM_MASTERS - 1 ? '0 : i + 1'b1;
  endfunction
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_MASTERS);
  endfunction
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    gnt_idx = '0;
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    start = state == ARB_LOCKED ? nxt(owner) : ptr;
    if (!hold) begin
      if (state == ARB_LOCKED && req[owner]) begin
        gnt_valid = 1'b1;
        gnt_idx = owner;
      end else begin
        for (int k = NUM_MASTERS - 1; k >= 0; k--)
          if (req[wrap(int'(start) + k)]) begin
            gnt_valid = 1'b1;
            gnt_idx = wrap(int'(start) + k);
          end
      end
      gnt[gnt_idx] = gnt_valid;
      if (gnt_valid) begin
        state_n = lock[gnt_idx] ? ARB_LOCKED : ARB_FREE;
        owner_n = gnt_idx;
        ptr_n = lock[gnt_idx] ? ptr : nxt(gnt_idx);
      end else if (state == ARB_LOCKED) begin
        state_n = ARB_FREE;
        ptr_n = nxt(owner);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARB_FREE;
      owner <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master byte bus arbiter with RAM/IO decode and 1-cycle read return; clk_in/rst_in/pause_in plus bus (slave modport)
module mem_bus_arbiter import mem_bus_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH = 3
) (
  input logic clk_in,
  input logic rst_in,
  input logic pause_in,
  mem_bus_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_MASTERS);
  logic [NUM_MASTERS-1:0] gnt;
  logic gv, wr, is_io, ram_hit, io_hit, rd_pend;
  logic [IW-1:0] gi, rd_idx;
  logic [RAM_ADDR_WIDTH:0] a;
  logic [DATA_W-1:0] wd, ram_din_q, io_din_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_a_q;
  logic [IO_SEL_WIDTH-1:0] io_sel_q;
  region_t rd_region;
  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
    .clk(clk_in),
    .rst(rst_in),
    .hold(pause_in | rst_in),
    .req(bus.m_req),
    .lock(bus.m_lock),
    .gnt(gnt),
    .gnt_valid(gv),
    .gnt_idx(gi)
  );
  assign a = bus.m_addr[gi*ADDR_WIDTH +: RAM_ADDR_WIDTH+1];
  assign wd = bus.m_wdata[gi*DATA_W +: DATA_W];
  assign wr = bus.m_wr[gi];
  assign is_io = a[RAM_ADDR_WIDTH -: 2] == REGION_IO;
  assign ram_hit = gv && !is_io;
  assign io_hit = gv && is_io;
  assign bus.m_gnt = gnt;
  assign bus.ram_en = ram_hit;
  assign bus.ram_r_nw = ram_hit ? !wr : 1'b1;
  assign bus.ram_a = ram_hit ? a[RAM_ADDR_WIDTH-1:0] : ram_a_q;
  assign bus.ram_din = ram_hit ? wd : ram_din_q;
  assign bus.io_en = io_hit;
  assign bus.io_wr = io_hit && wr;
  assign bus.io_sel = io_hit ? a[IO_SEL_WIDTH-1:0] : io_sel_q;
  assign bus.io_din = io_hit ? wd : io_din_q;
  assign bus.m_rvalid = rd_pend ? NUM_MASTERS'(1) << rd_idx : '0;
  assign bus.m_rdata = !rd_pend ? '0 : rd_region == REG_IO ? bus.io_dout : bus.ram_dout;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      ram_a_q <= '0;
      ram_din_q <= '0;
      io_sel_q <= '0;
      io_din_q <= '0;
      rd_pend <= 1'b0;
      rd_idx <= '0;
      rd_region <= REG_RAM;
    end else begin
      if (ram_hit) begin
        ram_a_q <= a[RAM_ADDR_WIDTH-1:0];
        ram_din_q <= wd;
      end
      if (io_hit) begin
        io_sel_q <= a[IO_SEL_WIDTH-1:0];
        io_din_q <= wd;
      end
      rd_pend <= gv && !wr;
      rd_idx <= gi;
      rd_region <= is_io ? REG_IO : REG_RAM;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with a behavioural RAM and fixed io_dout
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;
  typedef struct {int idx; logic [7:0] data; int due;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pause = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ptr = 0;
  exp_t sb[$];
  logic [7:0] wmem [int];
  mem_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .IO_SEL_WIDTH(3)) bus();
  mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .IO_SEL_WIDTH(3)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .pause_in(pause),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] pat(input int a);
    return a == 'h10 ? 8'hA5 : 8'(a) ^ 8'h5A;
  endfunction
  function automatic logic [7:0] rd(input int a);
    return wmem.exists(a) ? wmem[a] : pat(a);
  endfunction
  always @(posedge clk)
    if (bus.ram_en) begin
      bus.ram_dout <= rd(int'(bus.ram_a));
      if (!bus.ram_r_nw) wmem[int'(bus.ram_a)] = bus.ram_din;
    end
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.m_rvalid !== 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected got rvalid=%b rdata=%h at cycle %0d, expected none", bus.m_rvalid, bus.m_rdata, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.m_rvalid !== 2'(1 << e.idx) || bus.m_rdata !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rvalid got rvalid=%b rdata=%h cycle=%0d, expected rvalid=%b rdata=%h cycle=%0d",
                   bus.m_rvalid, bus.m_rdata, cyc, 2'(1 << e.idx), e.data, e.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rvalid_missing got none at cycle %0d, expected master %0d data %h", cyc, sb[0].idx, sb[0].data);
      sb.delete(0);
    end
  end
  task automatic drive(input logic p, input logic [1:0] req, lock, wr, input logic [31:0] a0, a1, input logic [7:0] d0, d1);
    @(posedge clk);
    #1;
    pause = p;
    bus.m_req = req;
    bus.m_lock = lock;
    bus.m_wr = wr;
    bus.m_addr = {a1, a0};
    bus.m_wdata = {d1, d0};
    @(negedge clk);
  endtask
  task automatic expect_rd(input int idx, input logic [7:0] d);
    sb.push_back('{idx, d, cyc + 1});
  endtask
  task automatic test_reset();
    bus.m_req = '0;
    bus.m_lock = '0;
    bus.m_wr = '0;
    bus.m_addr = '0;
    bus.m_wdata = '0;
    bus.io_dout = 8'h5C;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.m_gnt, bus.m_rvalid, bus.ram_en, bus.io_en, bus.ram_r_nw, bus.io_wr} !== 8'b0000_0010) begin
      errors++;
      $display("FAIL reset_ctrl got gnt=%b rvalid=%b ram_en=%b io_en=%b r_nw=%b io_wr=%b, expected 00 00 0 0 1 0",
               bus.m_gnt, bus.m_rvalid, bus.ram_en, bus.io_en, bus.ram_r_nw, bus.io_wr);
    end
    checks++;
    if (bus.ram_a !== 17'h0 || bus.io_sel !== 3'h0 || bus.m_rdata !== 8'h0 || bus.ram_din !== 8'h0 || bus.io_din !== 8'h0) begin
      errors++;
      $display("FAIL reset_data got ram_a=%h io_sel=%h rdata=%h ram_din=%h io_din=%h, expected all 0",
               bus.ram_a, bus.io_sel, bus.m_rdata, bus.ram_din, bus.io_din);
    end
    rst = 1'b0;
    ptr = 0;
  endtask
  task automatic test_ram_read();
    drive(0, 2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 8'h0, 8'h0);
    checks++;
    if (bus.m_gnt !== 2'b01 || {bus.ram_en, bus.ram_r_nw, bus.io_en} !== 3'b110 || bus.ram_a !== 17'h10) begin
      errors++;
      $display("FAIL ram_read got gnt=%b en/rnw/io=%b ram_a=%h, expected 01 110 00010", bus.m_gnt, {bus.ram_en, bus.ram_r_nw, bus.io_en}, bus.ram_a);
    end
    expect_rd(0, 8'hA5);
    ptr = 1;
    drive(0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
    checks++;
    if (bus.m_gnt !== 2'b00 || bus.ram_en !== 1'b0 || bus.ram_r_nw !== 1'b1 || bus.ram_a !== 17'h10) begin
      errors++;
      $display("FAIL idle_hold got gnt=%b ram_en=%b r_nw=%b ram_a=%h, expected 00 0 1 00010", bus.m_gnt, bus.ram_en, bus.ram_r_nw, bus.ram_a);
    end
  endtask
  task automatic test_round_robin();
    int n0, n1;
    logic [1:0] eg;
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 2'b11, 2'b00, 2'b01, 32'h200 + n0, 32'h40 + n1, 8'(8'h30 + n0), 8'h0);
      eg = ptr == 0 ? 2'b01 : 2'b10;
      checks++;
      if (bus.m_gnt !== eg) begin
        errors++;
        $display("FAIL rr_gnt step %0d got %b, expected %b", c, bus.m_gnt, eg);
      end
      if (eg == 2'b10) begin
        expect_rd(1, pat(32'h40 + n1));
        n1++;
      end else n0++;
      ptr = 1 - ptr;
    end
    drive(0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
    checks++;
    if (rd('h200) !== 8'h30 || rd('h201) !== 8'h31 || rd('h202) !== 8'h32) begin
      errors++;
      $display("FAIL rr_writes got %h %h %h, expected 30 31 32", rd('h200), rd('h201), rd('h202));
    end
  endtask
  task automatic test_lock();
    drive(0, 2'b10, 2'b00, 2'b10, 32'h0, 32'h0FF, 8'h0, 8'hBF);
    for (int k = 0; k < 4; k++) begin
      drive(0, k == 0 ? 2'b10 : 2'b11, k < 3 ? 2'b10 : 2'b00, 2'b10, 32'h103, 32'h100 + k, 8'h0, 8'(8'hC0 + k));
      checks++;
      if (bus.m_gnt !== 2'b10) begin
        errors++;
        $display("FAIL lock_hold byte %0d got %b, expected 10", k, bus.m_gnt);
      end
    end
    drive(0, 2'b01, 2'b00, 2'b00, 32'h103, 32'h0, 8'h0, 8'h0);
    checks++;
    if (bus.m_gnt !== 2'b01) begin
      errors++;
      $display("FAIL lock_after got %b, expected 01", bus.m_gnt);
    end
    expect_rd(0, 8'hC3);
    for (int k = 0; k < 3; k++) begin
      drive(0, 2'b01, 2'b00, 2'b00, 32'h100 + k, 32'h0, 8'h0, 8'h0);
      expect_rd(0, 8'(8'hC0 + k));
    end
    drive(0, 2'b10, 2'b10, 2'b10, 32'h0, 32'h1F0, 8'h0, 8'h66);
    drive(0, 2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 8'h0, 8'h0);
    checks++;
    if (bus.m_gnt !== 2'b01) begin
      errors++;
      $display("FAIL lock_drop got %b, expected 01", bus.m_gnt);
    end
    expect_rd(0, 8'hA5);
    ptr = 1;
    drive(0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
  endtask
  task automatic test_io();
    drive(0, 2'b01, 2'b00, 2'b00, 32'h30004, 32'h0, 8'h0, 8'h0);
    checks++;
    if (bus.m_gnt !== 2'b01 || bus.io_en !== 1'b1 || bus.io_wr !== 1'b0 || bus.io_sel !== 3'b100 || bus.ram_en !== 1'b0) begin
      errors++;
      $display("FAIL io_read got gnt=%b io_en=%b io_wr=%b io_sel=%b ram_en=%b, expected 01 1 0 100 0",
               bus.m_gnt, bus.io_en, bus.io_wr, bus.io_sel, bus.ram_en);
    end
    expect_rd(0, 8'h5C);
    drive(0, 2'b10, 2'b00, 2'b10, 32'h0, 32'h30007, 8'h0, 8'h77);
    checks++;
    if (bus.io_en !== 1'b1 || bus.io_wr !== 1'b1 || bus.io_sel !== 3'b111 || bus.io_din !== 8'h77 || bus.ram_en !== 1'b0) begin
      errors++;
      $display("FAIL io_write got io_en=%b io_wr=%b io_sel=%b io_din=%h ram_en=%b, expected 1 1 111 77 0",
               bus.io_en, bus.io_wr, bus.io_sel, bus.io_din, bus.ram_en);
    end
    drive(0, 2'b01, 2'b00, 2'b00, 32'hFFF0_0010, 32'h0, 8'h0, 8'h0);
    checks++;
    if (bus.ram_en !== 1'b1 || bus.io_en !== 1'b0 || bus.ram_a !== 17'h10) begin
      errors++;
      $display("FAIL high_bits got ram_en=%b io_en=%b ram_a=%h, expected 1 0 00010", bus.ram_en, bus.io_en, bus.ram_a);
    end
    expect_rd(0, 8'hA5);
    drive(0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
  endtask
  task automatic test_pause();
    drive(0, 2'b01, 2'b00, 2'b00, 32'h41, 32'h0, 8'h0, 8'h0);
    expect_rd(0, pat('h41));
    drive(1, 2'b11, 2'b10, 2'b10, 32'h42, 32'h181, 8'h0, 8'h11);
    checks++;
    if (bus.m_gnt !== 2'b00 || bus.ram_en !== 1'b0 || bus.io_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_block got gnt=%b ram_en=%b io_en=%b, expected 00 0 0", bus.m_gnt, bus.ram_en, bus.io_en);
    end
    drive(0, 2'b11, 2'b00, 2'b10, 32'h42, 32'h181, 8'h0, 8'h11);
    checks++;
    if (bus.m_gnt !== 2'b10) begin
      errors++;
      $display("FAIL pause_resume got %b, expected 10", bus.m_gnt);
    end
    drive(0, 2'b10, 2'b10, 2'b10, 32'h42, 32'h182, 8'h0, 8'h12);
    drive(1, 2'b11, 2'b10, 2'b10, 32'h42, 32'h183, 8'h0, 8'h13);
    drive(1, 2'b11, 2'b10, 2'b10, 32'h42, 32'h183, 8'h0, 8'h13);
    checks++;
    if (bus.m_gnt !== 2'b00) begin
      errors++;
      $display("FAIL pause_locked got %b, expected 00", bus.m_gnt);
    end
    drive(0, 2'b11, 2'b00, 2'b10, 32'h42, 32'h183, 8'h0, 8'h13);
    checks++;
    if (bus.m_gnt !== 2'b10) begin
      errors++;
      $display("FAIL pause_lock_kept got %b, expected 10", bus.m_gnt);
    end
    drive(0, 2'b11, 2'b00, 2'b10, 32'h42, 32'h184, 8'h0, 8'h14);
    checks++;
    if (bus.m_gnt !== 2'b01) begin
      errors++;
      $display("FAIL pause_after_release got %b, expected 01", bus.m_gnt);
    end
    expect_rd(0, pat('h42));
    drive(0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
  endtask
  task automatic test_reset_mid();
    drive(0, 2'b01, 2'b00, 2'b00, 32'h20, 32'h0, 8'h0, 8'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.m_rvalid !== 2'b00 || bus.m_gnt !== 2'b00 || bus.ram_en !== 1'b0 || bus.ram_r_nw !== 1'b1 || bus.ram_a !== 17'h0) begin
      errors++;
      $display("FAIL reset_mid got rvalid=%b gnt=%b ram_en=%b r_nw=%b ram_a=%h, expected 00 00 0 1 00000",
               bus.m_rvalid, bus.m_gnt, bus.ram_en, bus.ram_r_nw, bus.ram_a);
    end
    @(negedge clk);
    bus.m_req = 2'b00;
    rst = 1'b0;
    drive(0, 2'b11, 2'b00, 2'b00, 32'h21, 32'h22, 8'h0, 8'h0);
    checks++;
    if (bus.m_gnt !== 2'b01) begin
      errors++;
      $display("FAIL reset_ptr got %b, expected 01", bus.m_gnt);
    end
    expect_rd(0, pat('h21));
    drive(0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
    drive(0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
  endtask
  initial begin
    test_reset();
    test_ram_read();
    test_round_robin();
    test_lock();
    test_io();
    test_pause();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got no finish, expected finish before 100000");
    $fatal(1);
  end
endmodule
